mac_bitserial_collector: RTL and testbench
==========================================

Name: mac_bitserial_collector

Overview:
- Consumer end of the clocked MAC accumulator output.
- Takes one reduced partial sum per cycle, one per weight bit-plane, MSB plane first.
- Shift-accumulates NUM_BITS-or-fewer planes into a full-precision dot-product result and presents it to downstream logic (requantizer/writeback) over a valid/ready handshake.
- Handles two's-complement weights: the MSB plane carries negative weight.

Parameters:
- IN_WIDTH, 26, width of signed partial sum from accumulator (DATA_WIDTH+2).
- NUM_BITS, 8, maximum weight precision (bit-planes per group), 2..16.
- OUT_WIDTH, IN_WIDTH+NUM_BITS, width of signed collected result.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- clear  input  1  synchronous abort of the in-progress group.
- prec  input  4  group precision in planes; sampled on the first beat of a group.
- signed_w  input  1  1 = weights two's complement (MSB plane negative); sampled on the first beat.
- in_valid  input  1  partial sum valid.
- in_ready  output  1  beat accepted when in_valid & in_ready.
- in_data  input  IN_WIDTH  signed partial sum of the current plane.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  OUT_WIDTH  signed collected result.
- busy  output  1  group in progress (cnt != 0).

Behaviour:
- State: acc[OUT_WIDTH], cnt (0..NUM_BITS-1), prec_q, sgn_q, output register out_data/out_valid.
- Reset: acc=0, cnt=0, prec_q=1, sgn_q=0, out_valid=0, out_data=0, busy=0. Reset mid-group discards all partial state and any pending result.
- Effective precision: prec==0 → 1; prec>NUM_BITS → NUM_BITS.
- First beat (cnt==0): latch effective prec and signed_w.
  - Plane value is -in_data if signed_w=1, else +in_data.
  - Both are sign-extended to OUT_WIDTH before any arithmetic.
- Subsequent beats: acc = (acc<<1) + sext(in_data).
- Last beat: cnt == P-1, where P is the latched effective precision.
  - The final value (acc update included) is written to out_data; out_valid=1; cnt returns to 0.
  - Any new beat in the same cycle starts a new group only on the following cycle.
  - P=1: a single beat is both first and last. Result = -in_data (signed) or in_data (unsigned).
- in_ready = !clear & !(is_last_beat & out_valid & !out_ready).
  - Non-last beats are never stalled.
  - A last beat stalls only while the output register is full and not draining.
  - Same-cycle drain+refill is allowed, giving full throughput.
- out_valid clears on out_ready when no new result is loaded that cycle. out_data holds stable while out_valid & !out_ready.
- clear:
  - Forces cnt=0 and acc=0.
  - Beat not accepted that cycle.
  - Output register unaffected; a pending result remains valid.
- Latency: out_valid asserts the cycle after the last beat is accepted.
- Arithmetic: no overflow is possible within OUT_WIDTH for P<=NUM_BITS; no saturation.

Optional Feature:
- Macro: MAC_COLLECT_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt, 16 bits, reset 0.
  - Increments each cycle in_valid & !in_ready & !clear.
  - Saturates at 0xFFFF.
  - Cleared by reset only.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Unsigned, prec=4, beats 3,1,0,2 back-to-back with out_ready=1 → out_data=30, out_valid 1 cycle after 4th beat, busy high for cycles 1-3.
- Signed, prec=4, same beats 3,1,0,2 → out_data=-18. Then signed, prec=2, beats -5,7 → out_data=17.
- prec=1 signed in=5 → -5; prec=0 unsigned in=9 → 9 (treated as 1); prec=15 with NUM_BITS=8 → group ends after 8 beats.
- Backpressure: out_ready=0 holding result 30; next group's first 3 beats are accepted, the 4th has in_ready=0. Raise out_ready → same-cycle drain+load, second result follows, no beat lost.
- clear after 2 of 4 beats with a prior result pending → pending result unchanged. Next 4 beats 1,0,0,1 unsigned → 9.
- Reset asserted mid-group and with out_valid=1 → all outputs 0 next cycle. Macro build: stall_cnt equals the stalled-cycle count in the backpressure test.

Source files
------------

// File: rtl/mac_bitserial_collector.sv
// mac_bitserial_collector: bit-serial shift-accumulate collector for MAC partial sums.
// Receives one signed partial sum per weight bit-plane (MSB plane first), folds the
// planes into a full-precision dot-product result, and hands it downstream over a
// valid/ready handshake. With signed weights the MSB plane is subtracted.
// Optional build macro: MAC_COLLECT_STALL_CNT_EN adds a saturating 16-bit stall_cnt port.

module mac_bitserial_collector #(
  parameter int IN_WIDTH  = 26,
  parameter int NUM_BITS  = 8,
  parameter int OUT_WIDTH = IN_WIDTH + NUM_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [3:0]           prec,
  input  logic                 signed_w,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 busy
`ifdef MAC_COLLECT_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  localparam int CntW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [4:0]           prec_q, prec_d;
  logic                 sgn_q, sgn_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;

  logic [4:0]           eff_prec;
  logic                 first_beat;
  logic                 is_last;
  logic                 accept;
  logic                 load;
  logic [OUT_WIDTH-1:0] in_ext;
  logic [OUT_WIDTH-1:0] acc_next;

  // Clamp the requested precision into 1..NUM_BITS.
  always_comb begin
    eff_prec = {1'b0, prec};
    if (prec == 4'd0) begin
      eff_prec = 5'd1;
    end else if ({1'b0, prec} > 5'(NUM_BITS)) begin
      eff_prec = 5'(NUM_BITS);
    end
  end

  assign first_beat = (cnt_q == '0);
  // On the first beat the live precision decides; afterwards the latched one does.
  assign is_last    = first_beat ? (eff_prec == 5'd1) : (5'(cnt_q) == (prec_q - 5'd1));
  assign in_ready   = !clear && !(is_last && out_valid_q && !out_ready);
  assign accept     = in_valid && in_ready;
  assign load       = accept && is_last;
  assign busy       = !first_beat;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;

  assign in_ext = {{(OUT_WIDTH - IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};

  // MSB plane seeds the accumulator (negated for signed weights); later planes shift-add.
  always_comb begin
    if (first_beat) begin
      acc_next = signed_w ? (~in_ext + 1'b1) : in_ext;
    end else begin
      acc_next = (acc_q << 1) + in_ext;
    end
  end

  // Group sequencing: beat counter, accumulator and first-beat attribute capture.
  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    prec_d = prec_q;
    sgn_d  = sgn_q;
    if (clear) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (accept) begin
      acc_d = acc_next;
      if (first_beat) begin
        prec_d = eff_prec;
        sgn_d  = signed_w;
      end
      cnt_d = is_last ? '0 : cnt_q + CntW'(1);
    end
  end

  // Output register: load on the last beat, otherwise drain on out_ready.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_next;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      prec_q      <= 5'd1;
      sgn_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      prec_q      <= prec_d;
      sgn_q       <= sgn_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef MAC_COLLECT_STALL_CNT_EN
  // Count cycles where an offered beat is held off by output backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && !clear && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_bitserial_collector.sv
// Self-checking bench for mac_bitserial_collector: directed scenarios followed by
// randomized traffic, all compared every cycle against a queue-based reference model.

module tb_mac_bitserial_collector;

  localparam int IW = 26;
  localparam int NB = 8;
  localparam int OW = IW + NB;

  logic          clk = 1'b0;
  logic          reset, clear, signed_w, in_valid, out_ready;
  logic [3:0]    prec;
  logic [IW-1:0] in_data;
  logic          in_ready, out_valid, busy;
  logic [OW-1:0] out_data;
`ifdef MAC_COLLECT_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  mac_bitserial_collector #(
    .IN_WIDTH (IW),
    .NUM_BITS (NB),
    .OUT_WIDTH(OW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .prec     (prec),
    .signed_w (signed_w),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
`ifdef MAC_COLLECT_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Reference model: the beats of the open group, and the output register contents.
  longint m_beats[$];
  int     m_p     = 1;
  bit     m_sgn   = 1'b0;
  bit     m_oval  = 1'b0;
  longint m_odata = 0;
  int     m_stall = 0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int eff(input int p);
    if (p == 0) return 1;
    if (p > NB) return NB;
    return p;
  endfunction

  // Dot-product value of a complete group: sum of plane * 2^(weight of plane).
  function automatic longint group_result();
    longint r = 0;
    longint val;
    for (int k = 0; k < m_p; k++) begin
      val = m_beats[k];
      if (k == 0 && m_sgn) val = -val;
      r += val * (longint'(1) <<< (m_p - 1 - k));
    end
    return r;
  endfunction

  // One clock: drive at negedge, compare against model, advance model across posedge.
  task automatic step(input bit rst, input bit clr, input bit v, input longint d,
                      input int p, input bit sw, input bit ordy);
    bit     exp_last, exp_rdy, ld;
    longint res;
    @(negedge clk);
    reset     = rst;
    clear     = clr;
    in_valid  = v;
    in_data   = d[IW-1:0];
    prec      = p[3:0];
    signed_w  = sw;
    out_ready = ordy;
    #1;
    exp_last = (m_beats.size() == 0) ? (eff(p) == 1) : (m_beats.size() == m_p - 1);
    exp_rdy  = !clr && !(exp_last && m_oval && !ordy);
    if (chk_en) begin
      check("in_ready", in_ready, exp_rdy);
      check("out_valid", out_valid, m_oval);
      check("out_data", $signed(out_data), m_odata);
      check("busy", busy, m_beats.size() != 0);
`ifdef MAC_COLLECT_STALL_CNT_EN
      check("stall_cnt", stall_cnt, m_stall);
`endif
    end
    ld  = 1'b0;
    res = 0;
    if (rst) begin
      m_beats.delete();
      m_p = 1; m_sgn = 1'b0; m_oval = 1'b0; m_odata = 0; m_stall = 0;
    end else begin
      if (v && !exp_rdy && !clr && m_stall < 65535) m_stall++;
      if (clr) begin
        m_beats.delete();
      end else if (v && exp_rdy) begin
        if (m_beats.size() == 0) begin
          m_p   = eff(p);
          m_sgn = sw;
        end
        m_beats.push_back(d);
        if (m_beats.size() == m_p) begin
          ld  = 1'b1;
          res = group_result();
          m_beats.delete();
        end
      end
      if (ld) begin
        m_oval  = 1'b1;
        m_odata = res;
      end else if (ordy) begin
        m_oval = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_group(input int p, input bit sw, input bit ordy, input longint q[$]);
    foreach (q[i]) step(1'b0, 1'b0, 1'b1, q[i], p, sw, ordy);
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 1'b0, 1'b0, 0, 4, 1'b0, ordy);
  endtask

  longint q[$];
  longint d;
  logic [IW-1:0] r;

  initial begin
    step(1'b1, 1'b0, 1'b0, 0, 4, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 0, 4, 1'b0, 1'b1);
    chk_en = 1'b1;
    check("reset_valid", out_valid, 0);
    check("reset_data", $signed(out_data), 0);
    check("reset_busy", busy, 0);

    // Unsigned and signed 4-plane groups, then a signed 2-plane group.
    q = '{3, 1, 0, 2};
    run_group(4, 1'b0, 1'b1, q);
    check("u4_valid", out_valid, 1);
    check("u4_data", $signed(out_data), 30);
    run_group(4, 1'b1, 1'b1, q);
    check("s4_data", $signed(out_data), -18);
    q = '{-5, 7};
    run_group(2, 1'b1, 1'b1, q);
    check("s2_data", $signed(out_data), 17);

    // Precision corner cases.
    q = '{5};
    run_group(1, 1'b1, 1'b1, q);
    check("p1_data", $signed(out_data), -5);
    q = '{9};
    run_group(0, 1'b0, 1'b1, q);
    check("p0_data", $signed(out_data), 9);
    q = '{1, 1, 1, 1, 1, 1, 1, 1};
    run_group(15, 1'b0, 1'b1, q);
    check("p15_busy", busy, 0);
    check("p15_data", $signed(out_data), 255);
    idle(1'b1);

    // Backpressure: result held, next group's last beat stalls until drain.
    q = '{3, 1, 0, 2};
    run_group(4, 1'b0, 1'b0, q);
    check("bp_hold", $signed(out_data), 30);
    q = '{1, 1, 1};
    run_group(4, 1'b0, 1'b0, q);
    step(1'b0, 1'b0, 1'b1, 1, 4, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1, 4, 1'b0, 1'b0);
    check("bp_stall", in_ready, 0);
    check("bp_held", $signed(out_data), 30);
    step(1'b0, 1'b0, 1'b1, 1, 4, 1'b0, 1'b1);
    check("bp_refill_valid", out_valid, 1);
    check("bp_refill_data", $signed(out_data), 15);
`ifdef MAC_COLLECT_STALL_CNT_EN
    check("bp_stall_cnt", stall_cnt, 2);
`endif
    idle(1'b1);

    // Clear mid-group with a result pending.
    q = '{3, 1, 0, 2};
    run_group(4, 1'b0, 1'b0, q);
    q = '{1, 1};
    run_group(4, 1'b0, 1'b0, q);
    step(1'b0, 1'b1, 1'b1, 7, 4, 1'b0, 1'b0);
    check("clr_pending_valid", out_valid, 1);
    check("clr_pending_data", $signed(out_data), 30);
    check("clr_busy", busy, 0);
    q = '{1, 0, 0, 1};
    run_group(4, 1'b0, 1'b1, q);
    check("clr_next_data", $signed(out_data), 9);

    // Reset mid-group with a pending result.
    q = '{3, 1, 0, 2};
    run_group(4, 1'b0, 1'b0, q);
    q = '{1, 1};
    run_group(4, 1'b0, 1'b0, q);
    step(1'b1, 1'b0, 1'b0, 0, 4, 1'b0, 1'b0);
    check("rst_valid", out_valid, 0);
    check("rst_data", $signed(out_data), 0);
    check("rst_busy", busy, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = IW'($urandom);
        d = longint'($signed(r));
      end else begin
        d = longint'($urandom_range(0, 31)) - 16;
      end
      step($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 9) < 7, d, $urandom_range(0, 15), 1'($urandom),
           $urandom_range(0, 9) < 6);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
